// File: rtl/two_phase_pkg.sv
// Shared types and constants for the two-phase clock sequencer.
//   seq_state_e : top-level sequencer states
//   phase_e     : position inside one 4-tick CPU cycle (P0..P3)
//   CycleW      : width of the completed-cycle counter
package two_phase_pkg;

  localparam int unsigned CycleW = 16;

  typedef enum logic [2:0] {
    StIdle,
    StReset,
    StRun,
    StPause,
    StStep,
    StDone
  } seq_state_e;

  // P0: clk1 high, P1: gap, P2: clk2 high, P3: gap
  typedef enum logic [1:0] {
    PhP0 = 2'd0,
    PhP1 = 2'd1,
    PhP2 = 2'd2,
    PhP3 = 2'd3
  } phase_e;

endpackage

// File: rtl/phase_gen.sv
// Phase counter and non-overlapping clk1/clk2 decode for one CPU cycle.
// Ports:
//   clk_i          : system clock, rising edge
//   clear_i        : synchronous clear (phase P0, clocks low, inactive)
//   enable_i       : next tick belongs to an active CPU cycle
//   phase_o        : phase currently shown on clk1_o/clk2_o
//   end_of_cycle_o : high during an active P3 tick (its closing edge ends the cycle)
//   clk1_o, clk2_o : registered phase clocks
module phase_gen
  import two_phase_pkg::*;
(
  input  logic       clk_i,
  input  logic       clear_i,
  input  logic       enable_i,
  output logic [1:0] phase_o,
  output logic       end_of_cycle_o,
  output logic       clk1_o,
  output logic       clk2_o
);

  phase_e phase_q, phase_d;
  logic   active_q;
  logic   clk1_q, clk2_q;

  // A cycle entered from an inactive tick always starts at P0; otherwise advance,
  // letting P3 wrap naturally into the P0 of the following cycle.
  always_comb begin
    phase_d = PhP0;
    if (enable_i && active_q) begin
      phase_d = phase_e'(phase_q + 2'd1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      phase_q  <= PhP0;
      active_q <= 1'b0;
      clk1_q   <= 1'b0;
      clk2_q   <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      active_q <= enable_i;
      clk1_q   <= enable_i && (phase_d == PhP0);
      clk2_q   <= enable_i && (phase_d == PhP2);
    end
  end

  assign phase_o        = phase_q;
  assign end_of_cycle_o = active_q && (phase_q == PhP3);
  assign clk1_o         = clk1_q;
  assign clk2_o         = clk2_q;

endmodule

// File: rtl/two_phase_seq.sv
// Two-phase processor clock sequencer: generates reset, free-run, pause and
// single-step sequences of non-overlapping clk1/clk2 phase clocks.
// Parameters:
//   RST_CYCLES : full cycles cpu_rst is held (1..15)
//   MAX_CYCLES : run cycles before DONE, 0 = unbounded
// Ports:
//   clk, rst (sync, active high), start/step/stop control pulses,
//   test/test2/test3 observation buses, clk1/clk2/cpu_rst processor outputs,
//   busy, done, cycle_cnt status.
// Optional feature: define TWO_PHASE_SEQ_SNAPSHOT_EN to add snap_test,
// snap_test2, snap_test3 and snap_valid, capturing the buses after every
// counted cycle.
module two_phase_seq
  import two_phase_pkg::*;
#(
  parameter int unsigned RST_CYCLES = 1,
  parameter int unsigned MAX_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step,
  input  logic              stop,
  input  logic [31:0]       test,
  input  logic [31:0]       test2,
  input  logic [31:0]       test3,
  output logic              clk1,
  output logic              clk2,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic [CycleW-1:0] cycle_cnt
`ifdef TWO_PHASE_SEQ_SNAPSHOT_EN
  ,
  output logic [31:0]       snap_test,
  output logic [31:0]       snap_test2,
  output logic [31:0]       snap_test3,
  output logic              snap_valid
`endif
);

  localparam logic [CycleW-1:0] MaxCnt  = CycleW'(MAX_CYCLES);
  localparam bit                MaxEn   = (MAX_CYCLES != 0);
  localparam logic [3:0]        RstLast = 4'(RST_CYCLES - 1);

  seq_state_e        state_q, state_d;
  logic [3:0]        rst_cnt_q, rst_cnt_d;
  logic [CycleW-1:0] cnt_q, cnt_d;
  logic              stop_pend_q, stop_pend_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              enable;
  logic              eoc;
  logic              snap_take;
  logic              stop_req;
  logic [1:0]        phase;
  logic              unused_sig;

  phase_gen u_phase_gen (
    .clk_i          (clk),
    .clear_i        (rst),
    .enable_i       (enable),
    .phase_o        (phase),
    .end_of_cycle_o (eoc),
    .clk1_o         (clk1),
    .clk2_o         (clk2)
  );

  // start outranks step/stop whenever they coincide
  assign stop_req = stop_pend_q | (stop & ~start);

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    cnt_d       = cnt_q;
    stop_pend_d = stop_pend_q;
    cpu_rst_d   = cpu_rst_q;
    done_d      = done_q;
    snap_take   = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StReset;
          rst_cnt_d = '0;
          cpu_rst_d = 1'b1;
        end
      end
      StReset: begin
        if (eoc) begin
          if (rst_cnt_q == RstLast) begin
            state_d   = StRun;
            cpu_rst_d = 1'b0;
          end else begin
            rst_cnt_d = rst_cnt_q + 4'd1;
          end
        end
      end
      StRun: begin
        // A stop mid-cycle is remembered so the cycle always completes.
        stop_pend_d = stop_req;
        if (eoc) begin
          cnt_d     = cnt_q + 1'b1;
          snap_take = 1'b1;
          if (MaxEn && (cnt_d == MaxCnt)) begin
            state_d     = StDone;
            done_d      = 1'b1;
            stop_pend_d = 1'b0;
          end else if (stop_req) begin
            state_d     = StPause;
            stop_pend_d = 1'b0;
          end
        end
      end
      StPause: begin
        if (start) begin
          state_d = StRun;
        end else if (step) begin
          state_d = StStep;
        end
      end
      StStep: begin
        if (eoc) begin
          cnt_d     = cnt_q + 1'b1;
          snap_take = 1'b1;
          if (MaxEn && (cnt_d == MaxCnt)) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StPause;
          end
        end
      end
      StDone: begin
        if (start) begin
          state_d   = StReset;
          rst_cnt_d = '0;
          cnt_d     = '0;
          cpu_rst_d = 1'b1;
          done_d    = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Phase clocks run in the tick after the edge whenever the next state is active.
    enable = (state_d == StReset) || (state_d == StRun) || (state_d == StStep);
    busy_d = enable;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rst_cnt_q   <= '0;
      cnt_q       <= '0;
      stop_pend_q <= 1'b0;
      cpu_rst_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      cnt_q       <= cnt_d;
      stop_pend_q <= stop_pend_d;
      cpu_rst_q   <= cpu_rst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign cpu_rst   = cpu_rst_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cycle_cnt = cnt_q;

`ifdef TWO_PHASE_SEQ_SNAPSHOT_EN
  logic [31:0] snap_test_q, snap_test2_q, snap_test3_q;
  logic        snap_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_test_q  <= '0;
      snap_test2_q <= '0;
      snap_test3_q <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      snap_valid_q <= snap_take;
      if (snap_take) begin
        snap_test_q  <= test;
        snap_test2_q <= test2;
        snap_test3_q <= test3;
      end
    end
  end

  assign snap_test  = snap_test_q;
  assign snap_test2 = snap_test2_q;
  assign snap_test3 = snap_test3_q;
  assign snap_valid = snap_valid_q;
  assign unused_sig = ^phase;
`else
  assign unused_sig = ^{phase, snap_take, test, test2, test3};
`endif

endmodule

// File: tb/tb_two_phase_seq.sv
// Self-checking bench for two_phase_seq. Expected per-tick output vectors are
// queued when a sequence is launched and popped as the DUT produces each tick.
// Vector layout: {11'b0, clk1, clk2, cpu_rst, busy, done, cycle_cnt[15:0]}.
module tb_two_phase_seq;

  logic        clk = 1'b0;
  logic        rst, start, step, stop;
  logic        rst_b, start_b, step_b, stop_b;
  logic [31:0] test, test2, test3;

  logic        clk1_a, clk2_a, cpu_rst_a, busy_a, done_a;
  logic [15:0] cnt_a;
  logic        clk1_b, clk2_b, cpu_rst_b, busy_b, done_b;
  logic [15:0] cnt_b;
`ifdef TWO_PHASE_SEQ_SNAPSHOT_EN
  logic [31:0] snap_test_a, snap_test2_a, snap_test3_a;
  logic        snap_valid_a;
  logic [31:0] snap_test_b, snap_test2_b, snap_test3_b;
  logic        snap_valid_b;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];

  always #5 clk = ~clk;

  two_phase_seq u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .step       (step),
    .stop       (stop),
    .test       (test),
    .test2      (test2),
    .test3      (test3),
    .clk1       (clk1_a),
    .clk2       (clk2_a),
    .cpu_rst    (cpu_rst_a),
    .busy       (busy_a),
    .done       (done_a),
    .cycle_cnt  (cnt_a)
`ifdef TWO_PHASE_SEQ_SNAPSHOT_EN
    ,
    .snap_test  (snap_test_a),
    .snap_test2 (snap_test2_a),
    .snap_test3 (snap_test3_a),
    .snap_valid (snap_valid_a)
`endif
  );

  two_phase_seq #(
    .RST_CYCLES (3),
    .MAX_CYCLES (8)
  ) u_dut_b (
    .clk        (clk),
    .rst        (rst_b),
    .start      (start_b),
    .step       (step_b),
    .stop       (stop_b),
    .test       (test),
    .test2      (test2),
    .test3      (test3),
    .clk1       (clk1_b),
    .clk2       (clk2_b),
    .cpu_rst    (cpu_rst_b),
    .busy       (busy_b),
    .done       (done_b),
    .cycle_cnt  (cnt_b)
`ifdef TWO_PHASE_SEQ_SNAPSHOT_EN
    ,
    .snap_test  (snap_test_b),
    .snap_test2 (snap_test2_b),
    .snap_test3 (snap_test3_b),
    .snap_valid (snap_valid_b)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] act_v(input int p, input logic r, input int c);
    return {11'd0, (p == 0), (p == 2), r, 1'b1, 1'b0, 16'(c)};
  endfunction

  function automatic logic [31:0] idle_v(input logic d, input int c);
    return {11'd0, 1'b0, 1'b0, 1'b0, 1'b0, d, 16'(c)};
  endfunction

  // Closed-form sequence after a start from IDLE with MAX_CYCLES=8.
  function automatic logic [31:0] seq_v(input int t, input int rc);
    int rt;
    rt = 4 * rc;
    if (t <= rt) return act_v((t - 1) % 4, 1'b1, 0);
    if (t <= rt + 32) return act_v((t - 1) % 4, 1'b0, (t - rt - 1) / 4);
    return idle_v(1'b1, 8);
  endfunction

  function automatic logic [31:0] obs_a();
    return {11'd0, clk1_a, clk2_a, cpu_rst_a, busy_a, done_a, cnt_a};
  endfunction

  function automatic logic [31:0] obs_b();
    return {11'd0, clk1_b, clk2_b, cpu_rst_b, busy_b, done_b, cnt_b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_a(input string tag);
    logic [31:0] exp;
    exp = (q_a.size() != 0) ? q_a.pop_front() : 'x;
    check_val(tag, obs_a(), exp);
  endtask

  task automatic pop_b(input string tag);
    logic [31:0] exp;
    exp = (q_b.size() != 0) ? q_b.pop_front() : 'x;
    check_val(tag, obs_b(), exp);
  endtask

  task automatic reset_a();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q_a.push_back(32'd0);
    pop_a("rst_state_a");
  endtask

  int n_clk1, n_clk2, n_crst;

  initial begin
    rst = 1'b1; start = 1'b0; step = 1'b0; stop = 1'b0;
    rst_b = 1'b1; start_b = 1'b0; step_b = 1'b0; stop_b = 1'b0;
    test = 32'h0000_00A5; test2 = 32'h0000_005A; test3 = 32'h0000_003C;
    tick();
    tick();
    rst = 1'b0;
    rst_b = 1'b0;
    q_a.push_back(32'd0);
    q_b.push_back(32'd0);
    pop_a("rst_state_a");
    pop_b("rst_state_b");

    // Default run on A, RST_CYCLES=3 run on B, then restart A from DONE.
    start = 1'b1;
    start_b = 1'b1;
    for (int t = 1; t <= 46; t++) begin
      if (t <= 41) q_a.push_back(seq_v(t, 1));
      else if (t <= 45) q_a.push_back(act_v(t - 42, 1'b1, 0));
      else q_a.push_back(act_v(0, 1'b0, 0));
      q_b.push_back(seq_v(t, 3));
    end
    tick();
    start = 1'b0;
    start_b = 1'b0;
    for (int t = 1; t <= 46; t++) begin
      pop_a($sformatf("run_a t=%0d", t));
      pop_b($sformatf("run_b t=%0d", t));
`ifdef TWO_PHASE_SEQ_SNAPSHOT_EN
      begin
        logic sv_exp;
        sv_exp = (t >= 9) && (t <= 37) && ((t - 9) % 4 == 0);
        check_val($sformatf("snap_valid t=%0d", t), {31'd0, snap_valid_a}, {31'd0, sv_exp});
        if (sv_exp) begin
          check_val($sformatf("snap_test t=%0d", t), snap_test_a, 32'h0000_00A5);
          check_val($sformatf("snap_test2 t=%0d", t), snap_test2_a, 32'h0000_005A);
        end
      end
`endif
      if (t == 41) start = 1'b1;
      tick();
      start = 1'b0;
    end
    check_val("drain_a1", q_a.size(), 0);

    // Stop at P1 of cycle 3, two single steps, then start+step resumes RUN.
    reset_a();
    for (int t = 1; t <= 41; t++) begin
      if (t <= 16) q_a.push_back(seq_v(t, 1));
      else if (t <= 22) q_a.push_back(idle_v(1'b0, 3));
      else if (t <= 26) q_a.push_back(act_v(t - 23, 1'b0, 3));
      else if (t <= 29) q_a.push_back(idle_v(1'b0, 4));
      else if (t <= 33) q_a.push_back(act_v(t - 30, 1'b0, 4));
      else if (t <= 36) q_a.push_back(idle_v(1'b0, 5));
      else if (t <= 40) q_a.push_back(act_v(t - 37, 1'b0, 5));
      else q_a.push_back(act_v(0, 1'b0, 6));
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_clk1 = 0; n_clk2 = 0; n_crst = 0;
    for (int t = 1; t <= 41; t++) begin
      pop_a($sformatf("pause_a t=%0d", t));
      if (t >= 23 && t <= 36) begin
        n_clk1 += int'(clk1_a);
        n_clk2 += int'(clk2_a);
        n_crst += int'(cpu_rst_a);
      end
      if (t == 8 || t == 22 || t == 29 || t == 36) step = 1'b1;
      if (t == 14 || t == 19) stop = 1'b1;
      if (t == 36) start = 1'b1;
      tick();
      step = 1'b0;
      stop = 1'b0;
      start = 1'b0;
    end
    check_val("step_clk1_pulses", n_clk1, 2);
    check_val("step_clk2_pulses", n_clk2, 2);
    check_val("step_cpu_rst", n_crst, 0);
    check_val("drain_a2", q_a.size(), 0);

    // rst during P2 of run cycle 4, then a fresh start performs a full RESET.
    reset_a();
    for (int t = 1; t <= 31; t++) begin
      if (t <= 19) q_a.push_back(seq_v(t, 1));
      else if (t <= 22) q_a.push_back(32'd0);
      else if (t <= 26) q_a.push_back(act_v(t - 23, 1'b1, 0));
      else if (t <= 30) q_a.push_back(act_v(t - 27, 1'b0, 0));
      else q_a.push_back(act_v(0, 1'b0, 1));
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 1; t <= 31; t++) begin
      pop_a($sformatf("midrst_a t=%0d", t));
      if (t == 19) rst = 1'b1;
      if (t == 22) start = 1'b1;
      tick();
      rst = 1'b0;
      start = 1'b0;
    end
    check_val("drain_a3", q_a.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
